// File: rtl/alu_pwr_pkg.sv
// rtl/alu_pwr_pkg.sv - ALU power sequencer state encodings, widths and per-state output map
package alu_pwr_pkg;

  localparam int CNT_W  = 8;
  localparam int IDLE_W = 16;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWR_UP  = 3'd1,
    ST_ON      = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_ISO_SET = 3'd4
  } pwr_state_e;

  typedef struct packed {
    logic pwr_en;
    logic iso;
    logic ready;
  } pwr_out_t;

  function automatic pwr_out_t state_outputs(input pwr_state_e s);
    pwr_out_t o;
    o = '{pwr_en: 1'b0, iso: 1'b1, ready: 1'b0};
    case (s)
      ST_PWR_UP:  o = '{pwr_en: 1'b1, iso: 1'b1, ready: 1'b0};
      ST_ON:      o = '{pwr_en: 1'b1, iso: 1'b0, ready: 1'b1};
      ST_DRAIN:   o = '{pwr_en: 1'b1, iso: 1'b0, ready: 1'b0};
      ST_ISO_SET: o = '{pwr_en: 1'b1, iso: 1'b1, ready: 1'b0};
      default:    o = '{pwr_en: 1'b0, iso: 1'b1, ready: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pwr_delay_cnt.sv
// rtl/pwr_delay_cnt.sv - loadable down-counter timing the PWR_UP and ISO_SET windows
module pwr_delay_cnt
  import alu_pwr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/alu_pwr_seq.sv
// rtl/alu_pwr_seq.sv - ALU power-sequencing controller; ALU_AUTO_SLEEP_EN adds idle auto-sleep
module alu_pwr_seq
  import alu_pwr_pkg::*;
#(
  parameter int PWR_UP_CYC    = 4,
  parameter int ISO_SETUP_CYC = 2,
  parameter int IDLE_CYC      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       start_in,
  input  logic       alu_busy,
  output logic       start_out,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       alu_ready,
  output logic [2:0] pwr_state
);

  if (PWR_UP_CYC < 1 || PWR_UP_CYC > 255 || ISO_SETUP_CYC < 1 || ISO_SETUP_CYC > 255 ||
      IDLE_CYC < 1 || IDLE_CYC > 65535) begin : g_param_check
    $error("alu_pwr_seq: parameter out of range");
  end

  pwr_state_e       state_q, next_state;
  pwr_out_t         out_q;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val, cnt_val;
  logic             sleep_eff;

`ifdef ALU_AUTO_SLEEP_EN
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(IDLE_CYC);
  logic [IDLE_W-1:0] idle_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else if (state_q != ST_ON || start_in || alu_busy) begin
      idle_q <= '0;
    end else if (idle_q != IDLE_LIM) begin
      idle_q <= idle_q + 1'b1;
    end
  end

  assign sleep_eff = sleep_req | (idle_q == IDLE_LIM);
`else
  assign sleep_eff = sleep_req;
`endif

  // The counter only ticks inside the two timed states and holds at zero.
  assign cnt_dec = (state_q == ST_PWR_UP || state_q == ST_ISO_SET) && (cnt_val != '0);

  pwr_delay_cnt u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .value    (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    next_state   = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      ST_OFF: begin
        if (wake_req) begin
          next_state   = ST_PWR_UP;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(PWR_UP_CYC - 1);
        end
      end
      ST_PWR_UP: begin
        if (cnt_zero) next_state = ST_ON;
      end
      ST_ON: begin
        if (sleep_eff && !wake_req) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wake_req) begin
          next_state = ST_ON;
        end else if (!alu_busy) begin
          next_state   = ST_ISO_SET;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(ISO_SETUP_CYC - 1);
        end
      end
      ST_ISO_SET: begin
        if (wake_req)      next_state = ST_ON;
        else if (cnt_zero) next_state = ST_OFF;
      end
      default: next_state = ST_OFF;
    endcase
  end

  // Outputs are decoded from next_state so they switch on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      out_q   <= state_outputs(ST_OFF);
    end else begin
      state_q <= next_state;
      out_q   <= state_outputs(next_state);
    end
  end

  assign alu_pwr_en = out_q.pwr_en;
  assign iso_en     = out_q.iso;
  assign alu_ready  = out_q.ready;
  assign pwr_state  = state_q;
  assign start_out  = start_in & (state_q == ST_ON);

endmodule

// File: tb/tb_alu_pwr_seq.sv
// tb/tb_alu_pwr_seq.sv - directed table-driven bench for alu_pwr_seq
module tb_alu_pwr_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sleep_req, wake_req, start_in, alu_busy;
  logic       start_out, alu_pwr_en, iso_en, alu_ready;
  logic [2:0] pwr_state;

  int errors = 0;
  int checks = 0;

  alu_pwr_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sleep_req  (sleep_req),
    .wake_req   (wake_req),
    .start_in   (start_in),
    .alu_busy   (alu_busy),
    .start_out  (start_out),
    .alu_pwr_en (alu_pwr_en),
    .iso_en     (iso_en),
    .alu_ready  (alu_ready),
    .pwr_state  (pwr_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sleep, wake, start, busy;
    logic       so;
    logic [2:0] st;
    logic       pwr, iso, rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sl, input logic wk, input logic st_in, input logic bs,
                     input logic so, input logic [2:0] st, input logic pw, input logic is,
                     input logic rd);
    vec_t v;
    v.sleep = sl; v.wake = wk; v.start = st_in; v.busy = bs;
    v.so = so; v.st = st; v.pwr = pw; v.iso = is; v.rdy = rd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sticky invariant monitor, sampled on the falling edge.
  logic inv_bad  = 1'b0;
  logic mon_ok   = 1'b0;
  logic prev_pwr = 1'b0;
  logic prev_iso = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_ok <= 1'b0;
    end else begin
      if (mon_ok) begin
        if (prev_pwr && !alu_pwr_en && !prev_iso && iso_en) inv_bad <= 1'b1;
        if (!prev_iso && iso_en && !prev_pwr && alu_pwr_en) inv_bad <= 1'b1;
        if (prev_iso && !iso_en && !prev_pwr && alu_pwr_en) inv_bad <= 1'b1;
      end
      if (start_out && !alu_ready) inv_bad <= 1'b1;
      mon_ok <= 1'b1;
    end
    prev_pwr <= alu_pwr_en;
    prev_iso <= iso_en;
  end

  initial begin
    int n;

    //  sl wk st bs | so st pw is rd
    add(0, 1, 1, 0,   0, 1, 1, 1, 0);
    add(0, 0, 0, 0,   0, 1, 1, 1, 0);
    add(0, 0, 0, 0,   0, 1, 1, 1, 0);
    add(0, 0, 0, 0,   0, 1, 1, 1, 0);
    add(0, 0, 0, 0,   0, 2, 1, 0, 1);
    add(0, 0, 1, 0,   1, 2, 1, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 0, 2, 1, 0, 1);
    add(1, 0, 0, 1,   0, 3, 1, 0, 0);
    add(1, 0, 1, 1,   0, 3, 1, 0, 0);
    add(1, 0, 1, 1,   0, 3, 1, 0, 0);
    add(1, 0, 0, 0,   0, 4, 1, 1, 0);
    add(1, 0, 0, 0,   0, 4, 1, 1, 0);
    add(1, 0, 0, 0,   0, 0, 0, 1, 0);
    add(1, 0, 1, 0,   0, 0, 0, 1, 0);
    add(0, 1, 0, 0,   0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0,   0, 2, 1, 0, 1);
    add(1, 0, 0, 0,   0, 3, 1, 0, 0);
    add(1, 0, 0, 0,   0, 4, 1, 1, 0);
    add(0, 1, 1, 0,   0, 2, 1, 0, 1);
    for (int i = 0; i < 3; i++) add(1, 1, 1, 0, 1, 2, 1, 0, 1);
    add(1, 0, 0, 0,   0, 3, 1, 0, 0);
    add(0, 1, 1, 1,   0, 2, 1, 0, 1);
    add(0, 0, 1, 0,   1, 2, 1, 0, 1);

    sleep_req = 0; wake_req = 0; start_in = 0; alu_busy = 0;
    rst_n = 0;
    step();
    step();
    chk("rst_state", 32'(pwr_state), 0);
    chk("rst_pwr",   32'(alu_pwr_en), 0);
    chk("rst_iso",   32'(iso_en), 1);
    chk("rst_ready", 32'(alu_ready), 0);
    rst_n = 1;

    for (int i = 0; i < vecs.size(); i++) begin
      sleep_req = vecs[i].sleep;
      wake_req  = vecs[i].wake;
      start_in  = vecs[i].start;
      alu_busy  = vecs[i].busy;
      #1;
      chk($sformatf("v%0d_start_out", i), 32'(start_out), 32'(vecs[i].so));
      step();
      chk($sformatf("v%0d_state", i), 32'(pwr_state),  32'(vecs[i].st));
      chk($sformatf("v%0d_pwr", i),   32'(alu_pwr_en), 32'(vecs[i].pwr));
      chk($sformatf("v%0d_iso", i),   32'(iso_en),     32'(vecs[i].iso));
      chk($sformatf("v%0d_ready", i), 32'(alu_ready),  32'(vecs[i].rdy));
    end

    sleep_req = 0; wake_req = 0; start_in = 0; alu_busy = 0;
    rst_n = 0;
    #1;
    chk("async_rst_on_state", 32'(pwr_state), 0);
    chk("async_rst_on_pwr",   32'(alu_pwr_en), 0);
    chk("async_rst_on_iso",   32'(iso_en), 1);
    #5 rst_n = 1;

    wake_req = 1;
    step();
    wake_req = 0;
    step();
    rst_n = 0;
    #1;
    chk("async_rst_pu_state", 32'(pwr_state), 0);
    chk("async_rst_pu_pwr",   32'(alu_pwr_en), 0);
    chk("async_rst_pu_iso",   32'(iso_en), 1);
    chk("async_rst_pu_ready", 32'(alu_ready), 0);
    #5 rst_n = 1;

    wake_req = 1;
    step();
    wake_req = 0;
    chk("restart_state", 32'(pwr_state), 1);
    n = 0;
    while (pwr_state == 3'd1 && n < 20) begin
      n++;
      step();
    end
    chk("restart_pwr_up_cycles", 32'(n), 4);
    chk("restart_on_state", 32'(pwr_state), 2);
    chk("restart_on_iso", 32'(iso_en), 0);

`ifdef ALU_AUTO_SLEEP_EN
    repeat (10) step();
    chk("auto_idle10_state", 32'(pwr_state), 2);
    start_in = 1;
    step();
    start_in = 0;
    n = 0;
    while (pwr_state == 3'd2 && n < 100) begin
      n++;
      step();
    end
    chk("auto_after_pulse_edges", 32'(n), 17);
    chk("auto_drain_state", 32'(pwr_state), 3);
    wake_req = 1;
    step();
    wake_req = 0;
    chk("auto_wake_state", 32'(pwr_state), 2);
    n = 0;
    while (pwr_state == 3'd2 && n < 100) begin
      n++;
      step();
    end
    chk("auto_rewake_edges", 32'(n), 17);
`else
    repeat (40) step();
    chk("no_auto_sleep_state", 32'(pwr_state), 2);
    chk("no_auto_sleep_ready", 32'(alu_ready), 1);
`endif

    step();
    chk("invariants", 32'(inv_bad), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pwr_seq.md
Name: alu_pwr_seq

Overview:
- Power-sequencing controller directly upstream of the ALU datapath wrapper.
- Generates alu_pwr_en and iso_en in a safe order:
  - Power-down: drain in-flight ops, assert isolation, then remove power.
  - Power-up: apply power, wait for settling, then release isolation.
- Gates the upstream start strobe so no operation is issued while the ALU is not fully powered and de-isolated.

Parameters:
- PWR_UP_CYC, 4, cycles the block holds iso_en=1 after alu_pwr_en rises before entering ON; legal range 1..255.
- ISO_SETUP_CYC, 2, cycles iso_en=1 is held before alu_pwr_en falls; legal range 1..255.
- IDLE_CYC, 16, idle threshold for auto-sleep; legal range 1..65535; used only with ALU_AUTO_SLEEP_EN.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, asynchronous, active-low.
- sleep_req  in  1  level request to power the ALU down.
- wake_req  in  1  level request to power the ALU up.
- start_in  in  1  upstream operation start strobe.
- alu_busy  in  1  ALU multi-cycle op in progress (MUL/DIV).
- start_out  out  1  start to ALU; start_in AND (state==ON), combinational.
- alu_pwr_en  out  1  ALU power switch enable, registered.
- iso_en  out  1  ALU output isolation clamp, registered.
- alu_ready  out  1  high only in ON, registered.
- pwr_state  out  3  current state encoding, for debug and status.

Behaviour:
- Reset (async, rst_n=0):
  - State = OFF.
  - alu_pwr_en=0, iso_en=1, alu_ready=0, pwr_state=OFF.
  - Counters cleared.
  - Applies mid-sequence too: any state returns to OFF immediately.
- State encodings (3 bits): OFF=0, PWR_UP=1, ON=2, DRAIN=3, ISO_SET=4.
- Outputs per state (pwr_en / iso / ready):
  - OFF: 0 / 1 / 0
  - PWR_UP: 1 / 1 / 0
  - ON: 1 / 0 / 1
  - DRAIN: 1 / 0 / 0
  - ISO_SET: 1 / 1 / 0
- Outputs are registered from the next state, so they change on the same edge as the state.
- Transitions:
  - OFF:
    - wake_req=1 -> PWR_UP, delay counter loaded with PWR_UP_CYC-1.
    - sleep_req is ignored.
  - PWR_UP:
    - Decrement each cycle; at count 0 -> ON.
    - Total PWR_UP residency is exactly PWR_UP_CYC cycles.
    - sleep_req and wake_req are ignored.
  - ON:
    - sleep_req=1 and wake_req=0 -> DRAIN.
    - If both requests are high, wake wins and the block stays ON.
  - DRAIN:
    - start_out is blocked.
    - wake_req=1 -> ON (abort power-down).
    - Otherwise alu_busy=0 -> ISO_SET, counter loaded with ISO_SETUP_CYC-1.
    - Minimum DRAIN residency is 1 cycle.
  - ISO_SET:
    - wake_req=1 -> ON (power never dropped, iso released).
    - Otherwise at count 0 -> OFF.
    - Total ISO_SET residency is ISO_SETUP_CYC cycles.
- Invariants (assertable):
  - alu_pwr_en never falls in the same cycle iso_en rises.
  - iso_en never falls in the same cycle alu_pwr_en rises.
  - start_out=1 implies alu_ready=1.
- start_in outside ON is dropped and not queued; the upstream must check alu_ready.
- alu_busy is sampled only in DRAIN.

Optional Feature:
- Macro: ALU_AUTO_SLEEP_EN.
- With the macro:
  - A 16-bit idle counter runs in ON.
  - It increments on each cycle with start_in=0 and alu_busy=0, saturating at IDLE_CYC.
  - It clears on start_in=1, alu_busy=1, or any non-ON state.
  - When the counter equals IDLE_CYC and wake_req=0, the block behaves as if sleep_req=1.
- Without the macro:
  - No idle counter is built.
  - IDLE_CYC is unused.
  - Power-down occurs only on sleep_req.

Decomposition:
- Package alu_pwr_pkg holds:
  - The state typedef and its 3-bit encodings.
  - The counter width constant (8 bits).
  - The idle counter width constant (16 bits).
- Sub-module pwr_delay_cnt is natural:
  - Loadable 8-bit down-counter with load, value and zero flag.
  - Shared by PWR_UP and ISO_SET.

Test Plan:
- Reset then wake_req=1 for 1 cycle, default parameters:
  - alu_pwr_en=1 next edge.
  - iso_en stays 1 for 4 cycles, then 0 with alu_ready=1.
  - pwr_state sequence 0,1,1,1,1,2.
- In ON, alu_busy=1 for 5 cycles, then sleep_req=1:
  - DRAIN holds until alu_busy=0.
  - iso_en rises one edge later.
  - alu_pwr_en falls exactly 2 cycles after iso_en rises.
  - start_in pulses during DRAIN give start_out=0.
- In ISO_SET, assert wake_req:
  - Next edge state=ON, iso_en=0.
  - alu_pwr_en stays 1 throughout.
- sleep_req=1 and wake_req=1 together in ON:
  - Remains ON indefinitely.
  - Drop wake_req -> DRAIN next edge.
- rst_n low during PWR_UP at count 2:
  - alu_pwr_en=0 and iso_en=1 immediately, without waiting for a clock edge.
  - Restarting with wake_req gives full 4-cycle PWR_UP residency.
- With ALU_AUTO_SLEEP_EN, IDLE_CYC=16:
  - 16 idle ON cycles -> DRAIN.
  - A start_in pulse at idle cycle 10 resets the count, so DRAIN occurs 16 idle cycles after that pulse.
